// File: rtl/code_loader_pkg.sv
// ============================================================================
// Module      : code_loader_pkg
// Description : Shared loader states and code memory geometry.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package code_loader_pkg;

    localparam int CODE_ADDR_W = 6;
    localparam int CODE_DATA_W = 16;
    localparam int CODE_DEPTH  = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        WR   = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/code_loader.sv
// ============================================================================
// Module      : code_loader
// Description : Streams byte pairs (high byte first) into the code memory
//               write port and holds the CPU while loading.
//               Optional trailing XOR checksum byte: CODE_LOADER_CHECKSUM_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module code_loader
    import code_loader_pkg::*;
#(
    parameter int ADDR_W = CODE_ADDR_W,
    parameter int DATA_W = CODE_DATA_W,
    parameter int DEPTH  = CODE_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic              c1,
    output logic [ADDR_W-1:0] write_select,
    output logic [DATA_W-1:0] inp,
    output logic              mem_run,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_inp;
    logic              r_ready;
    logic              r_c1;
    logic              r_run;
    logic              r_hold;
    logic              r_done;
    logic              w_take;
    logic              w_last;
    logic [ADDR_W:0]   w_len;

    assign w_take = byte_valid && r_ready;
    assign w_last = (r_count + c_ONE) == r_len;
    assign w_len  = (load_len > c_DEPTH) ? c_DEPTH : load_len;

`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_error;
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // Outputs are registered: each transition loads the values of the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_inp   <= '0;
            r_ready <= 1'b0;
            r_c1    <= 1'b0;
            r_run   <= 1'b1;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
            r_csum  <= '0;
            r_error <= 1'b0;
`endif
        end else begin
            r_c1   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_hold  <= 1'b1;
                        r_run   <= 1'b0;
                        r_addr  <= '0;
                        r_count <= '0;
                        r_len   <= w_len;
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
                        r_error <= 1'b0;
`endif
                        if (w_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= HI;
                            r_ready <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (w_take) begin
                        r_inp[DATA_W-1 -: 8] <= byte_in;
                        r_state              <= LO;
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_csum               <= r_csum ^ byte_in;
`endif
                    end
                end
                LO: begin
                    if (w_take) begin
                        r_inp[7:0] <= byte_in;
                        r_state    <= WR;
                        r_ready    <= 1'b0;
                        r_c1       <= 1'b1;
                        r_run      <= 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ byte_in;
`endif
                    end
                end
                WR: begin
                    // Address wraps to 0 after the 64th write; the length check stops further writes.
                    r_run   <= 1'b0;
                    r_addr  <= r_addr + 1'b1;
                    r_count <= r_count + c_ONE;
                    if (w_last) begin
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_state <= CSUM;
                        r_ready <= 1'b1;
`else
                        r_state <= DONE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state <= HI;
                        r_ready <= 1'b1;
                    end
                end
`ifdef CODE_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (w_take) begin
                        if (byte_in != r_csum) begin
                            r_error <= 1'b1;
                        end
                        r_state <= DONE;
                        r_ready <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_hold  <= 1'b0;
                    r_run   <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_hold  <= 1'b0;
                    r_run   <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready   = r_ready;
    assign c1           = r_c1;
    assign write_select = r_addr;
    assign inp          = r_inp;
    assign mem_run      = r_run;
    assign cpu_hold     = r_hold;
    assign done         = r_done;

endmodule

`default_nettype wire
